wb_conbus_rr: RTL and testbench



---
 rtl/wb_conbus_pkg.sv | 22 ++
 rtl/wb_rr_arbiter.sv | 42 ++++
 rtl/wb_conbus_rr.sv | 136 +++++++++++++
 tb/tb_wb_conbus_rr.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_conbus_pkg.sv
// Shared types and helpers for the wb_conbus_rr round-robin Wishbone interconnect.
package wb_conbus_pkg;

    localparam int WB_DAT_W = 32;
    localparam int WB_SEL_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        ERR
    } state_t;

    // Index of the set bit in a one-hot vector of up to 8 masters; 0 when empty.
    function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++)
            if (oh[i]) idx = 3'(i);
        return idx;
    endfunction

endpackage

// File: rtl/wb_rr_arbiter.sv
// Round-robin arbiter: registers a one-hot grant on load, clears it on advance and
// remembers the releasing master so the next search starts just past it.
module wb_rr_arbiter
    import wb_conbus_pkg::*;
#(
    parameter int NUM_MASTERS = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_MASTERS-1:0] req,
    input  logic                   load,
    input  logic                   advance,
    output logic [NUM_MASTERS-1:0] grant
);

    logic [2:0]             last_owner;
    logic [NUM_MASTERS-1:0] pick;

    // Walk from last_owner+N down to last_owner+1 so the nearest requester after last_owner wins.
    always_comb begin
        pick = '0;
        for (int i = NUM_MASTERS; i >= 1; i--)
            for (int j = 0; j < NUM_MASTERS; j++)
                if (req[j] && j == (int'(last_owner) + i) % NUM_MASTERS) begin
                    pick    = '0;
                    pick[j] = 1'b1;
                end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant      <= '0;
            last_owner <= 3'(NUM_MASTERS - 1);
        end else if (advance) begin
            grant      <= '0;
            last_owner <= onehot_to_idx(8'(grant));
        end else if (load) begin
            grant      <= pick;
        end
    end

endmodule

// File: rtl/wb_conbus_rr.sv
// Parametrised Wishbone shared bus: round-robin master arbitration, prefix slave decode,
// unmapped-address error and an optional stalled-slave timeout (macro WB_CONBUS_TIMEOUT_EN).
module wb_conbus_rr
    import wb_conbus_pkg::*;
#(
    parameter int                              NUM_MASTERS    = 2,
    parameter int                              NUM_SLAVES     = 6,
    parameter int                              S_ADDR_W       = 4,
    parameter logic [NUM_SLAVES*S_ADDR_W-1:0] S_ADDR_MAP     = {4'h6, 4'h5, 4'h4, 4'h3, 4'h2, 4'h0},
    parameter int                              TIMEOUT_CYCLES = 255
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_MASTERS*WB_DAT_W-1:0] m_adr_i,
    input  logic [NUM_MASTERS*WB_DAT_W-1:0] m_dat_i,
    input  logic [NUM_MASTERS*WB_SEL_W-1:0] m_sel_i,
    input  logic [NUM_MASTERS-1:0]          m_we_i,
    input  logic [NUM_MASTERS-1:0]          m_cyc_i,
    input  logic [NUM_MASTERS-1:0]          m_stb_i,
    output logic [WB_DAT_W-1:0]             m_dat_o,
    output logic [NUM_MASTERS-1:0]          m_ack_o,
    output logic [NUM_MASTERS-1:0]          m_err_o,
    output logic [WB_DAT_W-1:0]             s_adr_o,
    output logic [WB_DAT_W-1:0]             s_dat_o,
    output logic [WB_SEL_W-1:0]             s_sel_o,
    output logic                            s_we_o,
    output logic [NUM_SLAVES-1:0]           s_cyc_o,
    output logic [NUM_SLAVES-1:0]           s_stb_o,
    input  logic [NUM_SLAVES*WB_DAT_W-1:0]  s_dat_i,
    input  logic [NUM_SLAVES-1:0]           s_ack_i,
    output logic [NUM_MASTERS-1:0]          grant_o
);

    if (NUM_MASTERS < 1 || NUM_MASTERS > 8 || NUM_SLAVES < 1 || NUM_SLAVES > 16 ||
        TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("wb_conbus_rr: unsupported parameter set");
    end

    state_t                 state, state_nxt;
    logic [NUM_MASTERS-1:0] grant;
    logic                   arb_load, arb_adv;
    logic [2:0]             owner;
    logic                   owner_cyc, owner_stb;
    logic [NUM_SLAVES-1:0]  hit;
    logic                   hit_any, slave_ack, tmo_expire;

    wb_rr_arbiter #(.NUM_MASTERS(NUM_MASTERS)) u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (m_cyc_i),
        .load    (arb_load),
        .advance (arb_adv),
        .grant   (grant)
    );

    assign owner     = onehot_to_idx(8'(grant));
    assign owner_cyc = |(m_cyc_i & grant);
    assign owner_stb = |(m_stb_i & grant);
    assign s_we_o    = |(m_we_i & grant);
    assign s_adr_o   = m_adr_i[owner*WB_DAT_W +: WB_DAT_W];
    assign s_dat_o   = m_dat_i[owner*WB_DAT_W +: WB_DAT_W];
    assign s_sel_o   = m_sel_i[owner*WB_SEL_W +: WB_SEL_W];

    // Descending scan: an overlapping map resolves to the lowest slave index.
    always_comb begin
        hit = '0;
        for (int k = NUM_SLAVES - 1; k >= 0; k--)
            if (s_adr_o[WB_DAT_W-1 -: S_ADDR_W] == S_ADDR_MAP[k*S_ADDR_W +: S_ADDR_W]) begin
                hit    = '0;
                hit[k] = 1'b1;
            end
    end

    always_comb begin
        m_dat_o = '0;
        for (int k = 0; k < NUM_SLAVES; k++)
            if (hit[k]) m_dat_o = s_dat_i[k*WB_DAT_W +: WB_DAT_W];
    end

    assign hit_any   = |hit;
    assign slave_ack = |(s_ack_i & hit);
    assign s_cyc_o   = (state != IDLE && owner_cyc) ? hit : '0;
    assign s_stb_o   = (state == BUSY && owner_cyc && owner_stb) ? hit : '0;
    assign m_ack_o   = (state == BUSY && owner_cyc && owner_stb && slave_ack) ? grant : '0;
    assign m_err_o   = (state == ERR) ? grant : '0;
    assign grant_o   = grant;

`ifdef WB_CONBUS_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_cnt;
    logic             stalled;

    assign stalled    = state == BUSY && owner_cyc && owner_stb && hit_any && !slave_ack;
    assign tmo_expire = stalled && tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1);

    // Leaving BUSY (grant change) or any non-stalled cycle restarts the count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                       tmo_cnt <= '0;
        else if (stalled && !tmo_expire) tmo_cnt <= tmo_cnt + 1'b1;
        else                             tmo_cnt <= '0;
    end
`else
    assign tmo_expire = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        arb_load  = 1'b0;
        arb_adv   = 1'b0;
        case (state)
            IDLE: if (|m_cyc_i) begin
                arb_load  = 1'b1;
                state_nxt = BUSY;
            end
            BUSY: if (!owner_cyc) begin
                arb_adv   = 1'b1;
                state_nxt = IDLE;
            end else if ((owner_stb && !hit_any) || tmo_expire) begin
                state_nxt = ERR;
            end
            ERR: if (owner_cyc) begin
                state_nxt = BUSY;
            end else begin
                arb_adv   = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_wb_conbus_rr.sv
// Directed bench for wb_conbus_rr: 2 masters, 6 stub slaves with fixed ack latency.
module tb_wb_conbus_rr;

    localparam int NM = 2;
    localparam int NS = 6;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [NM*32-1:0] m_adr, m_dat;
    logic [NM*4-1:0]  m_sel;
    logic [NM-1:0]    m_we, m_cyc, m_stb;
    logic [31:0]      m_dat_o;
    logic [NM-1:0]    m_ack_o, m_err_o, grant_o;
    logic [31:0]      s_adr_o, s_dat_o;
    logic [3:0]       s_sel_o;
    logic             s_we_o;
    logic [NS-1:0]    s_cyc_o, s_stb_o, s_ack_i;
    logic [NS*32-1:0] s_dat_i;

    int vectors = 0;
    int miscompares = 0;
    int lat [NS] = '{1, 3, 2, 1, 1, 0};
    int wcnt [NS];
    int acks, errs, first, stbc, got;
    logic [31:0] rdat;

    assign s_dat_i = {32'h1000_0005, 32'h1000_0004, 32'h1000_0003,
                      32'h1000_0002, 32'h0000_00A5, 32'h1000_0000};

    wb_conbus_rr #(.NUM_MASTERS(NM), .NUM_SLAVES(NS), .TIMEOUT_CYCLES(16)) dut (
        .clk     (clk),
        .reset   (reset),
        .m_adr_i (m_adr),
        .m_dat_i (m_dat),
        .m_sel_i (m_sel),
        .m_we_i  (m_we),
        .m_cyc_i (m_cyc),
        .m_stb_i (m_stb),
        .m_dat_o (m_dat_o),
        .m_ack_o (m_ack_o),
        .m_err_o (m_err_o),
        .s_adr_o (s_adr_o),
        .s_dat_o (s_dat_o),
        .s_sel_o (s_sel_o),
        .s_we_o  (s_we_o),
        .s_cyc_o (s_cyc_o),
        .s_stb_o (s_stb_o),
        .s_dat_i (s_dat_i),
        .s_ack_i (s_ack_i),
        .grant_o (grant_o)
    );

    // Slave stubs: ack after lat[k] strobed cycles, one cycle wide; lat 0 never acks.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            s_ack_i <= '0;
            for (int k = 0; k < NS; k++) wcnt[k] <= 0;
        end else begin
            for (int k = 0; k < NS; k++) begin
                if (s_stb_o[k] && !s_ack_i[k] && lat[k] != 0) begin
                    if (wcnt[k] == lat[k] - 1) begin
                        s_ack_i[k] <= 1'b1;
                        wcnt[k]    <= 0;
                    end else begin
                        wcnt[k] <= wcnt[k] + 1;
                    end
                end else begin
                    s_ack_i[k] <= 1'b0;
                    if (!s_stb_o[k]) wcnt[k] <= 0;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got_v, input logic [63:0] exp_v);
        vectors++;
        if (got_v !== exp_v) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got_v, exp_v);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        #3;
    endtask

    task automatic mreq(input int m, input logic [31:0] a, input logic s);
        m_cyc[m] = 1'b1;
        m_stb[m] = s;
        m_adr[m*32 +: 32] = a;
    endtask

    task automatic mdrop(input int m);
        m_cyc[m] = 1'b0;
        m_stb[m] = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        m_cyc = '0;
        m_stb = '0;
        nxt();
        nxt();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        m_adr = '0; m_dat = '0; m_sel = '0; m_we = '0; m_cyc = '0; m_stb = '0;
        nxt(); nxt(); smp();
        chk("rst_grant", 64'(grant_o), 0);
        chk("rst_scyc", 64'(s_cyc_o), 0);
        chk("rst_sstb", 64'(s_stb_o), 0);
        chk("rst_ack", 64'(m_ack_o), 0);
        chk("rst_err", 64'(m_err_o), 0);
        nxt();
        reset = 1'b0;
        nxt(); smp();
        chk("idle_grant", 64'(grant_o), 0);
        nxt();

        // Single read from the uart stub
        mreq(0, 32'h2000_0004, 1'b1);
        acks = 0; first = -1; rdat = '0;
        for (int c = 0; c < 10; c++) begin
            smp();
            if (c == 1) begin
                chk("t1_grant", 64'(grant_o), 2'b01);
                chk("t1_sstb", 64'(s_stb_o), 6'b000010);
                chk("t1_sadr", 64'(s_adr_o), 32'h2000_0004);
            end
            if (m_ack_o[0]) begin
                acks++;
                if (first < 0) begin
                    first = c;
                    rdat  = m_dat_o;
                end
            end
            nxt();
            if (first >= 0) mdrop(0);
        end
        chk("t1_ack_cnt", 64'(acks), 1);
        chk("t1_ack_lat", 64'(first), 4);
        chk("t1_rdat", 64'(rdat), 32'h0000_00A5);
        smp();
        chk("t1_release", 64'(grant_o), 0);

        // Arbitration order and rotation
        do_reset();
        mreq(0, 32'h0, 1'b0);
        mreq(1, 32'h0, 1'b0);
        smp(); nxt(); smp();
        chk("t2_first", 64'(grant_o), 2'b01);
        mdrop(0);
        nxt(); smp();
        chk("t2_gap", 64'(grant_o), 0);
        m_cyc[0] = 1'b1;
        nxt(); smp();
        chk("t2_rot", 64'(grant_o), 2'b10);
        mdrop(0); mdrop(1);
        nxt();
        mreq(0, 32'h0, 1'b0);
        mreq(1, 32'h0, 1'b0);
        nxt(); smp();
        chk("t2_tie", 64'(grant_o), 2'b01);
        mdrop(0); mdrop(1);
        nxt(); nxt();

        // m1 burst of 4 writes while m0 waits with stb held
        m_we[1] = 1'b1;
        m_dat[63:32] = 32'hDEAD_BEEF;
        m_sel[7:4] = 4'h3;
        mreq(1, 32'h0000_0010, 1'b1);
        mreq(0, 32'h3000_0000, 1'b1);
        acks = 0;
        for (int c = 0; c < 30 && acks < 4; c++) begin
            smp();
            if (c >= 1) begin
                chk("t3_hold", 64'(grant_o), 2'b10);
                chk("t3_nonowner", 64'(m_ack_o[0] | m_err_o[0]), 0);
            end
            if (c == 1) begin
                chk("t3_sstb", 64'(s_stb_o), 6'b000001);
                chk("t3_sdat", 64'(s_dat_o), 32'hDEAD_BEEF);
                chk("t3_swe", 64'(s_we_o), 1);
                chk("t3_ssel", 64'(s_sel_o), 4'h3);
            end
            if (m_ack_o[1]) acks++;
            nxt();
        end
        chk("t3_burst_acks", 64'(acks), 4);
        mdrop(1);
        m_we = '0;
        smp();
        chk("t3_hold_end", 64'(grant_o), 2'b10);
        nxt(); smp();
        chk("t3_gap", 64'(grant_o), 0);
        nxt(); smp();
        chk("t3_handover", 64'(grant_o), 2'b01);
        got = 0; rdat = '0;
        for (int c = 0; c < 10; c++) begin
            if (m_ack_o[0] && got == 0) begin
                got  = 1;
                rdat = m_dat_o;
            end
            nxt();
            if (got != 0) mdrop(0);
            smp();
        end
        chk("t3_m0_ack", 64'(got), 1);
        chk("t3_m0_rdat", 64'(rdat), 32'h1000_0002);

        // Unmapped address
        mreq(0, 32'h7000_0000, 1'b1);
        errs = 0; acks = 0; first = -1;
        for (int c = 0; c < 6; c++) begin
            nxt(); smp();
            if (c == 0) begin
                chk("t4_grant", 64'(grant_o), 2'b01);
                chk("t4_scyc", 64'(s_cyc_o), 0);
            end
            chk("t4_sstb", 64'(s_stb_o), 0);
            if (m_err_o[0]) begin
                errs++;
                if (first < 0) first = c;
                mdrop(0);
            end
            if (m_ack_o[0]) acks++;
        end
        chk("t4_err_cnt", 64'(errs), 1);
        chk("t4_err_lat", 64'(first), 1);
        chk("t4_ack_cnt", 64'(acks), 0);

        // Slave that never acks
        mreq(0, 32'h6000_0000, 1'b1);
`ifdef WB_CONBUS_TIMEOUT_EN
        stbc = 0; first = -1;
        for (int c = 0; c < 40 && first < 0; c++) begin
            nxt(); smp();
            if (m_err_o[0]) first = stbc;
            else if (s_stb_o[5]) stbc++;
        end
        chk("t5_tmo_stb_cycles", 64'(first), 16);
        chk("t5_err_stb", 64'(s_stb_o[5]), 0);
`else
        errs = 0;
        for (int c = 0; c < 1000; c++) begin
            nxt(); smp();
            if (m_err_o[0]) errs++;
        end
        chk("t5_no_err", 64'(errs), 0);
        chk("t5_still_stb", 64'(s_stb_o), 6'b100000);
`endif
        mdrop(0);
        nxt(); nxt();

        // Reset in the middle of a strobed access
        mreq(0, 32'h6000_0000, 1'b1);
        nxt(); smp();
        chk("t6_pre_stb", 64'(s_stb_o), 6'b100000);
        m_cyc[1] = 1'b1;
        reset = 1'b1;
        #1;
        chk("t6_rst_stb", 64'(s_stb_o), 0);
        chk("t6_rst_cyc", 64'(s_cyc_o), 0);
        chk("t6_rst_grant", 64'(grant_o), 0);
        chk("t6_rst_resp", 64'({m_ack_o, m_err_o}), 0);
        nxt(); nxt();
        reset = 1'b0;
        nxt(); smp();
        chk("t6_first_grant", 64'(grant_o), 2'b01);
        mdrop(0); mdrop(1);
        nxt(); nxt();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
